// File: rtl/control_fsm_if.sv
// Signal bundle between the control sequencer and the datapath/memory side.
interface control_fsm_if;
    logic [6:0] opcode;
    logic       cmp_out;
    logic       mem_ready;
    logic [2:0] state;
    logic       halt;
    logic       fault;
    logic       mem_req;
    logic       mem_we;
    logic       instr_load;
    logic       reg_re1;
    logic       reg_re2;
    logic       reg_we;
    logic       alu_sel1;
    logic       alu_sel2;
    logic [2:0] alu_op;
    logic [1:0] wb_sel;
    logic       target_load;
    logic       pc_enable;
    logic       pc_load;

    modport master (
        input  opcode, cmp_out, mem_ready,
        output state, halt, fault, mem_req, mem_we, instr_load, reg_re1, reg_re2,
               reg_we, alu_sel1, alu_sel2, alu_op, wb_sel, target_load, pc_enable, pc_load
    );

    modport slave (
        output opcode, cmp_out, mem_ready,
        input  state, halt, fault, mem_req, mem_we, instr_load, reg_re1, reg_re2,
               reg_we, alu_sel1, alu_sel2, alu_op, wb_sel, target_load, pc_enable, pc_load
    );
endinterface

// File: rtl/control_fsm.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with optional memory timeout.
// Define CONTROL_ILLEGAL_TRAP_EN to halt with fault on illegal opcodes (default: NOP).
module control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int unsigned       CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_op_imm, is_op, is_lui, is_auipc, is_branch;
    logic is_load, is_store, is_jal, is_jalr, is_system;
    logic writes_rd, alu_pc_a, alu_imm_b, wait_expired;

    always_comb begin
        is_op_imm = (bus.opcode == OPC_OP_IMM);
        is_op     = (bus.opcode == OPC_OP);
        is_lui    = (bus.opcode == OPC_LUI);
        is_auipc  = (bus.opcode == OPC_AUIPC);
        is_branch = (bus.opcode == OPC_BRANCH);
        is_load   = (bus.opcode == OPC_LOAD);
        is_store  = (bus.opcode == OPC_STORE);
        is_jal    = (bus.opcode == OPC_JAL);
        is_jalr   = (bus.opcode == OPC_JALR);
        is_system = (bus.opcode == OPC_SYSTEM);
        writes_rd = is_op_imm | is_op | is_lui | is_auipc | is_load | is_jal | is_jalr;
        alu_pc_a  = is_auipc | is_jal;
        alu_imm_b = is_op_imm | is_lui | is_auipc | is_load | is_store | is_jalr;
    end

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic is_legal;
    assign is_legal = is_op_imm | is_op | is_lui | is_auipc | is_branch |
                      is_load | is_store | is_jal | is_jalr | is_system;
`endif

    // Counter stops one short of MEM_TIMEOUT: the edge that would reach it takes HALT instead.
    assign wait_expired = (MEM_TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cnt_d   = '0;
        unique case (state_q)
            S_FETCH, S_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_WRITEBACK;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else if (MEM_TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (is_system) begin
                    state_d = S_HALT;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                end else if (!is_legal) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
`endif
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state = state_q;
    assign bus.fault = fault_q;

    always_comb begin
        bus.halt        = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.instr_load  = 1'b0;
        bus.reg_re1     = 1'b0;
        bus.reg_re2     = 1'b0;
        bus.reg_we      = 1'b0;
        bus.alu_sel1    = 1'b0;
        bus.alu_sel2    = 1'b0;
        bus.alu_op      = 3'd0;
        bus.wb_sel      = 2'd0;
        bus.target_load = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.pc_load     = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.instr_load = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.reg_re1     = 1'b1;
                    bus.reg_re2     = 1'b1;
                    bus.alu_sel1    = 1'b1;
                    bus.alu_sel2    = 1'b1;
                    bus.target_load = 1'b1;
                end
                S_EXECUTE: begin
                    bus.alu_sel1 = alu_pc_a;
                    bus.alu_sel2 = alu_imm_b;
                    bus.alu_op   = is_branch ? 3'd1 : 3'd0;
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = is_store;
                end
                S_WRITEBACK: begin
                    bus.alu_sel1    = alu_pc_a;
                    bus.alu_sel2    = alu_imm_b;
                    bus.alu_op      = is_branch ? 3'd1 : 3'd0;
                    bus.pc_enable   = 1'b1;
                    bus.reg_we      = writes_rd;
                    bus.wb_sel      = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                    bus.pc_load     = (is_branch && bus.cmp_out) || is_jal || is_jalr;
                    // JALR target (rs1+imm) comes from the ALU in this state.
                    bus.target_load = is_jalr;
                end
                S_HALT:  bus.halt = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
